// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch stage with a DEPTH-entry prefetch queue of {pc, instr} pairs.
// Ports: clk, RST (async, active-high), halt, redirect/redirect_pc, imem_addr/imem_rdata (combinational
// instruction memory), out_valid/out_ready/out_pc/out_instr (head entry to decode), queue_count.
// Define IF_STATIC_JUMP_EN to follow J/JAL targets at fetch time instead of fetching pc+4.
module if_fetch_queue #(
  parameter int          ADDR_W   = 10,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                           clk,
  input  logic                           RST,
  input  logic                           halt,
  input  logic                           redirect,
  input  logic [31:0]                    redirect_pc,
  output logic [ADDR_W-1:0]              imem_addr,
  input  logic [31:0]                    imem_rdata,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [31:0]                    out_pc,
  output logic [31:0]                    out_instr,
  output logic [$clog2(DEPTH+1)-1:0]     queue_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [63:0]   mem_q [DEPTH];
  logic [31:0]   pc_q, pc_d, plus4, next_pc;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop, push;
  assign out_valid   = cnt_q != '0;
  assign out_pc      = out_valid ? mem_q[rd_q][63:32] : '0;
  assign out_instr   = out_valid ? mem_q[rd_q][31:0] : '0;
  assign queue_count = cnt_q;
  assign imem_addr   = pc_q[ADDR_W+1:2];
  assign pop         = out_valid & out_ready;
  // A full queue can still accept when the head leaves on the same edge.
  assign push        = !redirect && !halt && (cnt_q < CW'(DEPTH) || pop);
  assign plus4       = pc_q + 32'd4;
`ifdef IF_STATIC_JUMP_EN
  // J/JAL targets are known from the word itself, so fetch follows them with no bubble.
  assign next_pc = (imem_rdata[31:26] == 6'b000010 || imem_rdata[31:26] == 6'b000011)
                 ? {plus4[31:28], imem_rdata[25:0], 2'b00} : plus4;
`else
  assign next_pc = plus4;
`endif
  always_comb begin
    pc_d  = redirect ? {redirect_pc[31:2], 2'b00} : push ? next_pc : pc_q;
    rd_d  = redirect ? '0 : pop ? rd_q + PW'(1) : rd_q;
    wr_d  = redirect ? '0 : push ? wr_q + PW'(1) : wr_q;
    cnt_d = redirect ? '0 : (push && !pop) ? cnt_q + CW'(1) : (pop && !push) ? cnt_q - CW'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      pc_q  <= RESET_PC;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  // Storage needs no reset: entries are only visible through cnt_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {pc_q, imem_rdata};
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed table, jump/wrap sequences and randomized run against a queue model.
module tb_if_fetch_queue;
  localparam int AW = 10, D = 4;
  logic clk = 0, RST = 1, halt = 0, redirect = 0, out_ready = 0;
  logic [31:0] redirect_pc = 0, imem_rdata, out_pc, out_instr;
  logic [AW-1:0] imem_addr;
  logic out_valid;
  logic [2:0] queue_count;
  logic [31:0] imem [1024];
  assign imem_rdata = imem[imem_addr];
  always #5 clk = ~clk;

  if_fetch_queue #(.ADDR_W(AW), .DEPTH(D), .RESET_PC(32'h0)) dut (
    .clk(clk), .RST(RST), .halt(halt), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .queue_count(queue_count));

  int vecs = 0, errs = 0;
  typedef struct packed {logic [31:0] pc, ins;} ent_t;
  ent_t q[$];
  logic [31:0] mpc;

  typedef struct {
    logic h, r; logic [31:0] rp; logic rdy;
    logic v; logic [31:0] pc; logic [2:0] c; logic [9:0] a;
  } vec_t;
  vec_t tv[$];

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] nxt(logic [31:0] pc, logic [31:0] ins);
    logic [31:0] p4;
    p4 = pc + 32'd4;
`ifdef IF_STATIC_JUMP_EN
    if (ins[31:26] == 6'b000010 || ins[31:26] == 6'b000011) return {p4[31:28], ins[25:0], 2'b00};
`endif
    return p4;
  endfunction

  task automatic model_edge();
    bit pop, push;
    logic [31:0] w;
    if (redirect) begin
      q.delete();
      mpc = {redirect_pc[31:2], 2'b00};
    end else begin
      pop  = q.size() > 0 && out_ready;
      push = !halt && (q.size() < D || pop);
      if (pop) void'(q.pop_front());
      if (push) begin
        w = imem[mpc[11:2]];
        q.push_back('{mpc, w});
        mpc = nxt(mpc, w);
      end
    end
  endtask

  task automatic chk_model();
    ent_t h;
    h = q.size() > 0 ? q[0] : '0;
    cmp("m_valid", 32'(out_valid), 32'(q.size() > 0));
    cmp("m_pc", out_pc, h.pc);
    cmp("m_instr", out_instr, h.ins);
    cmp("m_count", 32'(queue_count), 32'(q.size()));
    cmp("m_addr", 32'(imem_addr), 32'(mpc[11:2]));
  endtask

  task automatic cyc(input logic h, input logic r, input logic [31:0] rp, input logic rdy);
    halt = h; redirect = r; redirect_pc = rp; out_ready = rdy;
    model_edge();
    @(negedge clk);
    chk_model();
  endtask

  function automatic void add(logic h, logic r, logic [31:0] rp, logic rdy,
                              logic v, logic [31:0] pc, logic [2:0] c, logic [9:0] a);
    tv.push_back('{h, r, rp, rdy, v, pc, c, a});
  endfunction

  logic [31:0] jexp [5];

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = 32'h1000_0000 + i;
    q.delete();
    mpc = 0;
    // free run
    add(0,0,0,1, 1,32'h0,1,1);  add(0,0,0,1, 1,32'h4,1,2);  add(0,0,0,1, 1,32'h8,1,3);
    // restart at 0 then stall decode until full
    add(0,1,0,1, 0,32'h0,0,0);
    add(0,0,0,0, 1,32'h0,1,1);  add(0,0,0,0, 1,32'h0,2,2);  add(0,0,0,0, 1,32'h0,3,3);
    add(0,0,0,0, 1,32'h0,4,4);  add(0,0,0,0, 1,32'h0,4,4);  add(0,0,0,0, 1,32'h0,4,4);
    // full with pop
    add(0,0,0,1, 1,32'h4,4,5);
    // halt drains
    add(1,0,0,1, 1,32'h8,3,5);  add(1,0,0,1, 1,32'hC,2,5);  add(1,0,0,1, 1,32'h10,1,5);
    add(1,0,0,1, 0,32'h0,0,5);  add(1,0,0,1, 0,32'h0,0,5);
    // three queued then redirect with concurrent pop
    add(0,0,0,0, 1,32'h14,1,6); add(0,0,0,0, 1,32'h14,2,7); add(0,0,0,0, 1,32'h14,3,8);
    add(0,1,32'h203,1, 0,32'h0,0,10'h80);
    add(0,0,0,1, 1,32'h200,1,10'h81);
    // halt together with redirect
    add(1,1,32'h10,1, 0,32'h0,0,4);
    add(0,0,0,1, 1,32'h10,1,5);

    #12;
    cmp("rst_valid", 32'(out_valid), 0);
    cmp("rst_pc", out_pc, 0);
    cmp("rst_instr", out_instr, 0);
    cmp("rst_count", 32'(queue_count), 0);
    cmp("rst_addr", 32'(imem_addr), 0);
    @(negedge clk);
    RST = 0;
    foreach (tv[i]) begin
      cyc(tv[i].h, tv[i].r, tv[i].rp, tv[i].rdy);
      cmp($sformatf("t%0d_valid", i), 32'(out_valid), 32'(tv[i].v));
      cmp($sformatf("t%0d_pc", i), out_pc, tv[i].pc);
      cmp($sformatf("t%0d_count", i), 32'(queue_count), 32'(tv[i].c));
      cmp($sformatf("t%0d_addr", i), 32'(imem_addr), 32'(tv[i].a));
    end

    // unconditional jump at 0x8
    imem[2] = 32'h0800_0010;
`ifdef IF_STATIC_JUMP_EN
    jexp = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h44};
`else
    jexp = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
`endif
    cyc(0, 1, 32'h0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1);
      cmp($sformatf("jmp%0d_pc", i), out_pc, jexp[i]);
    end
    imem[2] = 32'h1000_0002;

    // PC wrap at the top of the address space
    cyc(0, 1, 32'hFFFF_FFFF, 0);
    cmp("wrap_addr0", 32'(imem_addr), 32'h3FF);
    cyc(0, 0, 0, 0);
    cmp("wrap_head", out_pc, 32'hFFFF_FFFC);
    cmp("wrap_addr1", 32'(imem_addr), 0);

    // randomized run, with a couple of jump words in reach
    imem[50]  = 32'h0800_0100;
    imem[300] = 32'h0C00_0020;
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0,
          ($urandom_range(0, 7) == 0) ? 32'h0000_00C0 : 32'($urandom_range(0, 4095)),
          $urandom_range(0, 3) != 0);

    // asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    #2 RST = 1;
    #1;
    cmp("arst_valid", 32'(out_valid), 0);
    cmp("arst_count", 32'(queue_count), 0);
    cmp("arst_pc", out_pc, 0);
    cmp("arst_addr", 32'(imem_addr), 0);
    q.delete();
    mpc = 0;
    @(negedge clk);
    RST = 0;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage with a prefetch queue, replacing the single-register PC + instruction-store fetch path. The block owns the fetch PC, drives a combinational-read instruction memory, and buffers fetched {pc, instruction} pairs in a FIFO. The decode stage can therefore stall without stopping fetch. The block sits between the instruction store and the ID stage and accepts redirects (branch/jump/exception) from later stages.

## Interface
Parameters:
- ADDR_W, 10, word-address width of instruction memory
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, fetch PC after reset; low two bits must be 0

Ports:
- clk  in  1  single clock, rising edge
- RST  in  1  asynchronous, active-high reset
- halt  in  1  stop fetching; queue still drains
- redirect  in  1  flush queue and load redirect_pc
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced 0)
- imem_addr  out  ADDR_W  word address = fetch_pc[ADDR_W+1:2], combinational
- imem_rdata  in  32  instruction at imem_addr, same-cycle (combinational) read
- out_valid  out  1  head entry present
- out_ready  in  1  ID stage accepts head entry
- out_pc  out  32  PC of head entry
- out_instr  out  32  instruction of head entry
- queue_count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- State: fetch_pc (32b), FIFO of DEPTH × 64b entries, rd/wr pointers (log2 DEPTH bits, wrap modulo DEPTH), count.
- pop = out_valid & out_ready.
- push = !redirect & !halt & (count < DEPTH | pop). Entry written = {fetch_pc, imem_rdata}; fetch_pc ← next_pc.
- next_pc = fetch_pc + 4 (32-bit wrap, 32'hFFFF_FFFC → 0).
- redirect (highest priority): count ← 0, rd/wr pointers ← 0, fetch_pc ← {redirect_pc[31:2], 2'b00}, no push, any concurrent pop discarded.
- halt without redirect: fetch_pc holds, no push; pops continue.
- Full (count == DEPTH) with no pop: no push, fetch_pc holds. Full with pop: push and pop same edge, count unchanged.
- Empty: out_valid = 0; out_pc and out_instr = 0; out_ready ignored.
- count updates: +1 push only, −1 pop only, unchanged both/neither.

## Timing
- Reset (asynchronous, immediate): fetch_pc = RESET_PC, count = 0, pointers = 0, out_valid = 0, out_pc = 0, out_instr = 0, queue_count = 0, imem_addr = RESET_PC[ADDR_W+1:2].
- First edge after RST deasserts (halt=0) pushes RESET_PC entry; out_valid = 1 in the following cycle.
- Fetch-to-output latency: 1 cycle when queue is empty (registered FIFO, no bypass).
- Throughput: 1 instruction/cycle sustained with out_ready held high.
- Redirect asserted at edge k: queue empty during cycle k+1; redirect_pc entry visible on out at cycle k+2.
- RST asserted mid-operation discards all entries and in-flight redirect at once.

## Configuration
- IF_STATIC_JUMP_EN defined: at push, if imem_rdata[31:26] is 6'b000010 (J) or 6'b000011 (JAL), next_pc = {fetch_pc_plus4[31:28], imem_rdata[25:0], 2'b00}; the jump itself is still queued. No bubble on unconditional jumps; later-stage redirect overrides as usual.
- Undefined: next_pc is always fetch_pc + 4; jumps resolve only through redirect.

## Test plan
- Reset then free-run, out_ready=1, imem word n = 32'h1000_0000+n: out_pc sequence 0,4,8,… one per cycle from second cycle, out_instr matches, queue_count stays ≤1.
- out_ready=0 for 10 cycles (DEPTH=4): queue_count climbs 1,2,3,4 then holds; fetch_pc stalls at 0x10; on release, entries 0x0..0xC then 0x10 emerge in order, no gap or duplicate.
- Full queue plus pop same edge: count stays 4, new entry appended, head advances by one.
- redirect=1, redirect_pc=32'h0000_0203 while queue holds 3 entries and out_ready=1: next cycle out_valid=0, count=0; following cycle out_pc=0x200.
- halt=1 with 2 entries queued, out_ready=1: both drain, then out_valid=0, fetch_pc unchanged; halt and redirect together load redirect_pc, no push.
- With IF_STATIC_JUMP_EN, word at 0x8 = J 0x40 (32'h0800_0010): out_pc sequence 0x0,0x4,0x8,0x40,0x44 without bubble; without macro sequence 0x0,0x4,0x8,0xC.
